// File: rtl/dvi_transmitter_pkg.sv
// Shared TMDS constants for the DVI transmitter: control tokens, clock-lane
// pattern, disparity counter width and the per-symbol encoding choice.
package dvi_transmitter_pkg;

  localparam int unsigned CNT_W = 5;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  localparam logic [9:0] CLK_PATTERN = 10'b1111100000;

  typedef enum logic [1:0] {
    SEL_CTRL,
    SEL_BALANCED,
    SEL_INVERT,
    SEL_KEEP
  } enc_sel_e;

  function automatic logic [9:0] ctrl_token(input logic c1, input logic c0);
    case ({c1, c0})
      2'b00:   return CTRL_TOKEN_00;
      2'b01:   return CTRL_TOKEN_01;
      2'b10:   return CTRL_TOKEN_10;
      default: return CTRL_TOKEN_11;
    endcase
  endfunction

endpackage

// File: rtl/dvi_transmitter_tmds.sv
// One TMDS lane: stage 1 builds the transition-minimised q_m word, stage 2
// applies DC balancing against the lane's running disparity.
module tmds_encoder
  import dvi_transmitter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       c0,
  input  logic       c1,
  input  logic       de,
  output logic [9:0] dout
);

  localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

  logic [3:0]       n1d;
  logic             use_xnor;
  logic             acc;
  logic [8:0]       qm_d, qm_q;
  logic             de_q, c0_q, c1_q;
  logic [3:0]       n1, n0;
  logic [CNT_W-1:0] diff, cnt_d, cnt_q;
  logic             cnt_pos, cnt_neg;
  enc_sel_e         sel;
  logic [9:0]       dout_d, dout_q;

  always_comb begin
    n1d = '0;
    for (int unsigned i = 0; i < 8; i++) n1d = n1d + {3'b000, din[i]};
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !din[0]);
    acc      = din[0];
    qm_d     = '0;
    qm_d[0]  = din[0];
    for (int unsigned i = 1; i < 8; i++) begin
      acc     = use_xnor ? ~(acc ^ din[i]) : (acc ^ din[i]);
      qm_d[i] = acc;
    end
    qm_d[8] = ~use_xnor;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qm_q <= '0;
      de_q <= 1'b0;
      c0_q <= 1'b0;
      c1_q <= 1'b0;
    end else begin
      qm_q <= qm_d;
      de_q <= de;
      c0_q <= c0;
      c1_q <= c1;
    end
  end

  // Counter arithmetic is done modulo 2^CNT_W; the bit pattern equals the
  // signed result because the disparity never leaves -8..+8.
  always_comb begin
    n1 = '0;
    for (int unsigned i = 0; i < 8; i++) n1 = n1 + {3'b000, qm_q[i]};
    n0      = 4'd8 - n1;
    diff    = {1'b0, n1} - {1'b0, n0};
    cnt_neg = cnt_q[CNT_W-1];
    cnt_pos = !cnt_neg && (cnt_q != '0);

    if (!de_q)                                         sel = SEL_CTRL;
    else if ((cnt_q == '0) || (n1 == n0))              sel = SEL_BALANCED;
    else if ((cnt_pos && n1 > n0) || (cnt_neg && n0 > n1)) sel = SEL_INVERT;
    else                                               sel = SEL_KEEP;

    dout_d = ctrl_token(c1_q, c0_q);
    cnt_d  = '0;
    case (sel)
      SEL_BALANCED: begin
        dout_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
        cnt_d  = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
      end
      SEL_INVERT: begin
        dout_d = {1'b1, qm_q[8], ~qm_q[7:0]};
        cnt_d  = cnt_q - diff + (qm_q[8] ? CNT_TWO : '0);
      end
      SEL_KEEP: begin
        dout_d = {1'b0, qm_q[8], qm_q[7:0]};
        cnt_d  = cnt_q + diff - (qm_q[8] ? '0 : CNT_TWO);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= CTRL_TOKEN_00;
      cnt_q  <= '0;
    end else begin
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/dvi_transmitter_top.sv
// DVI TMDS transmitter front end: registers the RGB888 pixel and syncs, then
// encodes B/G/R on three lanes; serialization happens outside this block.
module dvi_transmitter_top
  import dvi_transmitter_pkg::*;
(
  input  logic        pclk,
  input  logic        reset,
  input  logic [23:0] video_din,
  input  logic        video_hsync,
  input  logic        video_vsync,
  input  logic        video_de,
  output logic [9:0]  tmds_ch0,
  output logic [9:0]  tmds_ch1,
  output logic [9:0]  tmds_ch2,
  output logic [9:0]  tmds_clk_word
);

  logic [23:0] din_q;
  logic        hsync_q, vsync_q, de_q;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      din_q   <= '0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      de_q    <= 1'b0;
    end else begin
      din_q   <= video_din;
      hsync_q <= video_hsync;
      vsync_q <= video_vsync;
      de_q    <= video_de;
    end
  end

  tmds_encoder u_enc_b (
    .clk  (pclk),
    .rst  (reset),
    .din  (din_q[7:0]),
    .c0   (hsync_q),
    .c1   (vsync_q),
    .de   (de_q),
    .dout (tmds_ch0)
  );

  tmds_encoder u_enc_g (
    .clk  (pclk),
    .rst  (reset),
    .din  (din_q[15:8]),
    .c0   (1'b0),
    .c1   (1'b0),
    .de   (de_q),
    .dout (tmds_ch1)
  );

  tmds_encoder u_enc_r (
    .clk  (pclk),
    .rst  (reset),
    .din  (din_q[23:16]),
    .c0   (1'b0),
    .c1   (1'b0),
    .de   (de_q),
    .dout (tmds_ch2)
  );

  assign tmds_clk_word = CLK_PATTERN;

endmodule

// File: tb/tb_dvi_transmitter_top.sv
// Self-checking bench for dvi_transmitter_top: per-cycle comparison against a
// behavioural TMDS model, lane decoding, and hand-computed literal symbols.
module tb_dvi_transmitter_top;

  logic        pclk        = 1'b0;
  logic        reset       = 1'b1;
  logic [23:0] video_din   = '0;
  logic        video_hsync = 1'b0;
  logic        video_vsync = 1'b0;
  logic        video_de    = 1'b0;
  logic [9:0]  tmds_ch0, tmds_ch1, tmds_ch2, tmds_clk_word;

  int checks   = 0;
  int failures = 0;

  always #5 pclk = ~pclk;

  dvi_transmitter_top dut (
    .pclk          (pclk),
    .reset         (reset),
    .video_din     (video_din),
    .video_hsync   (video_hsync),
    .video_vsync   (video_vsync),
    .video_de      (video_de),
    .tmds_ch0      (tmds_ch0),
    .tmds_ch1      (tmds_ch1),
    .tmds_ch2      (tmds_ch2),
    .tmds_clk_word (tmds_clk_word)
  );

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
  } px_t;

  px_t         p0, p1, exp_px;
  logic [9:0]  exp_sym [3];
  int          cnt_m [3];
  bit          cmp_en   = 1'b0;
  int          rec_mode = 0;
  logic [29:0] rec_q [$];
  logic [23:0] line_px [1920];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [9:0] enc(input logic [7:0] d, input logic de, input logic c0,
                                     input logic c1, input int cnt_in, output int cnt_out);
    logic [8:0] qm;
    logic [9:0] sym;
    int n1d, n1, n0;
    bit inv;
    cnt_out = cnt_in;
    if (!de) begin
      cnt_out = 0;
      case ({c1, c0})
        2'b00:   return 10'h354;
        2'b01:   return 10'h0AB;
        2'b10:   return 10'h154;
        default: return 10'h2AB;
      endcase
    end
    n1d   = $countones(d);
    inv   = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    qm    = '0;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = inv ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !inv;
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    if (cnt_in == 0 || n1 == n0) begin
      sym     = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt_out = cnt_in + (qm[8] ? (n1 - n0) : (n0 - n1));
    end else if ((cnt_in > 0 && n1 > n0) || (cnt_in < 0 && n0 > n1)) begin
      sym     = {1'b1, qm[8], ~qm[7:0]};
      cnt_out = cnt_in + 2 * (qm[8] ? 1 : 0) + n0 - n1;
    end else begin
      sym     = {1'b0, qm[8], qm[7:0]};
      cnt_out = cnt_in - 2 * (qm[8] ? 0 : 1) + n1 - n0;
    end
    return sym;
  endfunction

  function automatic logic [7:0] dec(input logic [9:0] s);
    logic [7:0] d, o;
    d    = s[9] ? ~s[7:0] : s[7:0];
    o    = '0;
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return o;
  endfunction

  // Model: the symbol after edge t encodes the inputs sampled at edge t-2.
  always @(posedge pclk or posedge reset) begin
    int c;
    if (reset) begin
      p0     = '0;
      p1     = '0;
      exp_px = '0;
      for (int k = 0; k < 3; k++) begin
        cnt_m[k]   = 0;
        exp_sym[k] = 10'h354;
      end
    end else begin
      exp_px     = p1;
      exp_sym[0] = enc(p1.rgb[7:0],   p1.de, p1.hs, p1.vs, cnt_m[0], c); cnt_m[0] = c;
      exp_sym[1] = enc(p1.rgb[15:8],  p1.de, 1'b0,  1'b0,  cnt_m[1], c); cnt_m[1] = c;
      exp_sym[2] = enc(p1.rgb[23:16], p1.de, 1'b0,  1'b0,  cnt_m[2], c); cnt_m[2] = c;
      p1 = p0;
      p0 = {video_de, video_hsync, video_vsync, video_din};
    end
  end

  always @(negedge pclk) begin
    if (cmp_en) begin
      chk("ch0", tmds_ch0, exp_sym[0]);
      chk("ch1", tmds_ch1, exp_sym[1]);
      chk("ch2", tmds_ch2, exp_sym[2]);
      chk("clk_word", tmds_clk_word, 10'h3E0);
      if (exp_px.de && !reset) begin
        chk("decode_rgb", {dec(tmds_ch2), dec(tmds_ch1), dec(tmds_ch0)}, exp_px.rgb);
        if (rec_mode == 1) begin
          rec_q.push_back({tmds_ch2, tmds_ch1, tmds_ch0});
        end else if (rec_mode == 2) begin
          chk("replay_avail", (rec_q.size() > 0) ? 1 : 0, 1);
          if (rec_q.size() > 0) chk("replay_line", {tmds_ch2, tmds_ch1, tmds_ch0}, rec_q.pop_front());
        end
      end
    end
  end

  task automatic drive(input logic de, input logic hs, input logic vs, input logic [23:0] rgb);
    video_de    = de;
    video_hsync = hs;
    video_vsync = vs;
    video_din   = rgb;
    @(negedge pclk);
  endtask

  task automatic blank(input int n, input logic hs, input logic vs);
    for (int i = 0; i < n; i++) drive(1'b0, hs, vs, 24'h0);
  endtask

  initial begin
    repeat (3) @(negedge pclk);
    chk("rst_ch0", tmds_ch0, 10'h354);
    chk("rst_ch1", tmds_ch1, 10'h354);
    chk("rst_ch2", tmds_ch2, 10'h354);
    chk("rst_clk", tmds_clk_word, 10'h3E0);
    cmp_en = 1'b1;
    reset  = 1'b0;
    blank(6, 1'b0, 1'b0);
    chk("idle_ch0", tmds_ch0, 10'h354);

    foreach (line_px[i]) line_px[i] = 24'($urandom);
    rec_mode = 1;
    foreach (line_px[i]) drive(1'b1, 1'b0, 1'b0, line_px[i]);
    blank(4, 1'b0, 1'b0);
    rec_mode = 0;
    blank(4, 1'b1, 1'b0);
    blank(3, 1'b0, 1'b0);

    blank(3, 1'b1, 1'b0);
    chk("hs_ch0", tmds_ch0, 10'h0AB);
    chk("hs_ch1", tmds_ch1, 10'h354);
    chk("hs_ch2", tmds_ch2, 10'h354);
    chk("model_hs_ch0", exp_sym[0], 10'h0AB);
    blank(3, 1'b0, 1'b1);
    chk("vs_ch0", tmds_ch0, 10'h154);
    blank(3, 1'b1, 1'b1);
    chk("hsvs_ch0", tmds_ch0, 10'h2AB);
    blank(3, 1'b0, 1'b0);
    chk("ctl00_ch0", tmds_ch0, 10'h354);

    repeat (3) drive(1'b1, 1'b0, 1'b0, 24'h000000);
    chk("b00_p0_ch0", tmds_ch0, 10'h100);
    chk("b00_p0_ch1", tmds_ch1, 10'h100);
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    chk("b00_p1_ch0", tmds_ch0, 10'h3FF);
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    chk("b00_p2_ch0", tmds_ch0, 10'h100);
    chk("model_b00_p2", exp_sym[0], 10'h100);
    blank(4, 1'b0, 1'b0);

    repeat (2) drive(1'b1, 1'b0, 1'b0, 24'h0FF0FF);
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    chk("bff_p0_ch0", tmds_ch0, 10'h200);
    chk("gf0_p0_ch1", tmds_ch1, 10'h205);
    chk("r0f_p0_ch2", tmds_ch2, 10'h105);
    chk("model_bff_p0", exp_sym[0], 10'h200);
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    chk("bff_p1_ch0", tmds_ch0, 10'h0FF);
    chk("gf0_p1_ch1", tmds_ch1, 10'h0FA);
    chk("r0f_p1_ch2", tmds_ch2, 10'h3FA);
    blank(4, 1'b0, 1'b0);

    for (int i = 0; i < 700; i++) drive(1'b1, 1'b0, 1'b0, ~line_px[i]);
    #2 reset = 1'b1;
    #1;
    chk("midrst_ch0", tmds_ch0, 10'h354);
    chk("midrst_ch1", tmds_ch1, 10'h354);
    chk("midrst_ch2", tmds_ch2, 10'h354);
    video_de  = 1'b0;
    video_din = '0;
    repeat (3) @(negedge pclk);
    chk("inrst_ch0", tmds_ch0, 10'h354);
    reset = 1'b0;
    blank(6, 1'b0, 1'b0);

    rec_mode = 2;
    foreach (line_px[i]) drive(1'b1, 1'b0, 1'b0, line_px[i]);
    blank(4, 1'b0, 1'b0);
    rec_mode = 0;
    chk("replay_left", rec_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dvi_transmitter_top.md
DVI_TRANSMITTER_TOP -- requirements
Module: dvi_transmitter_top

Interface
REQ-001 SHALL have the following ports; one clock; reset is asynchronous and active-high. Differential 10:1 serialization and pclk_x5 generation (pll_0/pll_1) are outside this block.
REQ-002 pclk  in  1  pixel clock, all logic on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 video_din  in  24  RGB888 pixel: [23:16]=R, [15:8]=G, [7:0]=B.
REQ-005 video_hsync  in  1  horizontal sync, passed as-is with no polarity change.
REQ-006 video_vsync  in  1  vertical sync, passed as-is with no polarity change.
REQ-007 video_de  in  1  data enable: 1 = active pixel, 0 = blanking.
REQ-008 tmds_ch0  out  10  TMDS symbol for the blue lane, bit 0 transmitted first.
REQ-009 tmds_ch1  out  10  TMDS symbol for the green lane.
REQ-010 tmds_ch2  out  10  TMDS symbol for the red lane.
REQ-011 tmds_clk_word  out  10  clock-lane pattern, constant 10'b1111100000.

Function
REQ-012 Each lane SHALL be encoded per DVI 1.0 TMDS with 2-pclk latency: input sampled at edge N, symbol valid after edge N+2; de and sync signals are delayed alongside the data.
REQ-013 Lane mapping SHALL be:
- ch0: B, with C0=hsync and C1=vsync.
- ch1: G, with C0=C1=0.
- ch2: R, with C0=C1=0.
REQ-014 Stage 1 SHALL compute q_m from data D, where n1D = number of ones in D:
- If n1D>4, or n1D==4 with D[0]==0: q_m[i]=~(q_m[i-1]^D[i]) and q_m[8]=0.
- Otherwise: q_m[i]=q_m[i-1]^D[i] and q_m[8]=1.
- In both cases q_m[0]=D[0].
REQ-015 Stage 2 SHALL keep a per-lane signed 5-bit running disparity cnt; n1 and n0 are the counts of ones and zeros in q_m[7:0].
REQ-016 If cnt==0 or n1==n0:
- out[9]=~q_m[8], out[8]=q_m[8].
- out[7:0]=q_m[8] ? q_m[7:0] : ~q_m[7:0].
- cnt += q_m[8] ? (n1-n0) : (n0-n1).
REQ-017 Else if (cnt>0 and n1>n0) or (cnt<0 and n0>n1):
- out={1, q_m[8], ~q_m[7:0]}.
- cnt += 2*q_m[8] + n0 - n1.
REQ-018 Otherwise:
- out={0, q_m[8], q_m[7:0]}.
- cnt += -2*(~q_m[8]) + n1 - n0.
REQ-019 When delayed de==0, the output SHALL be the control token selected by {C1,C0}, and cnt SHALL be forced to 0:
- 00 -> 10'b1101010100 (0x354).
- 01 -> 0x0AB.
- 10 -> 0x154.
- 11 -> 0x2AB.
REQ-020 A de transition in either direction SHALL take effect on the symbol exactly 2 cycles later, with no extra or dropped symbols.
REQ-021 cnt SHALL stay within -8..+8 and never wrap.

Reset
REQ-022 While reset=1, all pipeline registers SHALL clear to de=0, syncs=0, data=0, and cnt=0.
REQ-023 During reset, tmds_ch0..2 SHALL read 0x354 and tmds_clk_word SHALL read 0x3E0.
REQ-024 On reset release, the first encoded symbol SHALL appear at the 2nd rising edge after the first sampled input.

Structure
REQ-025 A shared package SHALL hold:
- the four control tokens;
- the clock pattern 10'b1111100000;
- the disparity width (5).
REQ-026 One sub-module, tmds_encoder (din[7:0], c0, c1, de -> dout[9:0], with its own cnt), SHALL be instantiated three times.

Verification
REQ-027 Assert reset -> all lanes 0x354, clk word 0x3E0; release reset with de=0 and syncs=0 -> lanes stay 0x354.
REQ-028 Apply de=0, hsync=1, vsync=0 -> after 2 cycles, ch0=0x0AB and ch1=ch2=0x354; with hsync=1, vsync=1 -> ch0=0x2AB.
REQ-029 Apply de=1 with B=0x00 for three consecutive pixels from cnt=0 -> ch0 sequence 0x100, 0x3FF, 0x100 (cnt -8, +2, -6).
REQ-030 Apply de=1 with B=0xFF from cnt=0 -> ch0=0x200, cnt=-8.
REQ-031 Run a 1920-pixel active line of random RGB -> decoded lanes reproduce the input RGB; cnt stays within ±8; cnt returns to 0 in blanking.
REQ-032 Assert reset mid-line -> outputs immediately 0x354; cnt=0; the next line encodes identically to the first line after power-up.
